// File: rtl/alu_exec_ctrl.sv
// rtl/alu_exec_ctrl.sv - ALU execution controller: single-cycle add/sub, iterative mul/div, valid/ready in and out
module alu_exec_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [1:0]       op_opcode,
  input  logic [WIDTH-1:0] rs1_reg_val,
  input  logic [WIDTH-1:0] rs2_reg_val,
  input  logic [2:0]       rd_addr,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_val,
  output logic [WIDTH-1:0] res_aux,
  output logic [2:0]       res_rd,
  output logic             res_zero,
  output logic             res_carry,
  output logic             res_dz,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t state, state_nx;

  logic [WIDTH-1:0] mcand, mplier, acc_hi, dvsr, rem, quo;
  logic [CW-1:0]    cnt;
  logic [2:0]       rd_q;

  logic [WIDTH:0]   addsub, mul_sum, div_shift;
  logic [WIDTH-1:0] mul_hi_nx, mul_lo_nx, rem_nx, quo_nx;
  logic             div_ok, last, accept, iterate;

  logic             load, ld_carry, ld_dz;
  logic [WIDTH-1:0] ld_val, ld_aux;
  logic [2:0]       ld_rd;

  assign op_ready  = (state == IDLE);
  assign res_valid = (state == DONE);
  assign busy      = (state == MUL) || (state == DIV);
  assign accept    = op_valid && op_ready;
  assign last      = (cnt == CW'(1));
  assign iterate   = (op_opcode == 2'd2) || ((op_opcode == 2'd3) && (rs2_reg_val != '0));

  // Bit WIDTH is carry for add and borrow for sub.
  assign addsub = (op_opcode == 2'd1) ? ({1'b0, rs1_reg_val} - {1'b0, rs2_reg_val})
                                      : ({1'b0, rs1_reg_val} + {1'b0, rs2_reg_val});

  assign mul_sum   = {1'b0, acc_hi} + (mplier[0] ? {1'b0, mcand} : '0);
  assign mul_hi_nx = mul_sum[WIDTH:1];
  assign mul_lo_nx = {mul_sum[0], mplier[WIDTH-1:1]};

  // The shifted remainder can reach WIDTH+1 bits; after a successful subtract it fits WIDTH again.
  assign div_shift = {rem, quo[WIDTH-1]};
  assign div_ok    = (div_shift >= {1'b0, dvsr});
  assign rem_nx    = div_ok ? (div_shift[WIDTH-1:0] - dvsr) : div_shift[WIDTH-1:0];
  assign quo_nx    = {quo[WIDTH-2:0], div_ok};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    ld_val   = '0;
    ld_aux   = '0;
    ld_carry = 1'b0;
    ld_dz    = 1'b0;
    ld_rd    = rd_q;
    case (state)
      IDLE: if (op_valid) begin
        case (op_opcode)
          2'd2: state_nx = MUL;
          2'd3: begin
            if (rs2_reg_val == '0) begin
              state_nx = DONE;
              load     = 1'b1;
              ld_val   = '1;
              ld_aux   = rs1_reg_val;
              ld_dz    = 1'b1;
              ld_rd    = rd_addr;
            end else begin
              state_nx = DIV;
            end
          end
          default: begin
            state_nx = DONE;
            load     = 1'b1;
            ld_val   = addsub[WIDTH-1:0];
            ld_carry = addsub[WIDTH];
            ld_rd    = rd_addr;
          end
        endcase
      end
      MUL: if (last) begin
        state_nx = DONE;
        load     = 1'b1;
        ld_val   = mul_lo_nx;
        ld_aux   = mul_hi_nx;
        ld_carry = |mul_hi_nx;
      end
      DIV: if (last) begin
        state_nx = DONE;
        load     = 1'b1;
        ld_val   = quo_nx;
        ld_aux   = rem_nx;
      end
      default: if (res_ready) state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand     <= '0;
      mplier    <= '0;
      acc_hi    <= '0;
      dvsr      <= '0;
      rem       <= '0;
      quo       <= '0;
      cnt       <= '0;
      rd_q      <= '0;
      res_val   <= '0;
      res_aux   <= '0;
      res_rd    <= '0;
      res_zero  <= 1'b0;
      res_carry <= 1'b0;
      res_dz    <= 1'b0;
    end else begin
      if (accept) begin
        mcand  <= rs1_reg_val;
        mplier <= rs2_reg_val;
        acc_hi <= '0;
        dvsr   <= rs2_reg_val;
        rem    <= '0;
        quo    <= rs1_reg_val;
        rd_q   <= rd_addr;
        if (iterate) cnt <= CW'(WIDTH);
      end else if (state == MUL) begin
        acc_hi <= mul_hi_nx;
        mplier <= mul_lo_nx;
        cnt    <= cnt - CW'(1);
      end else if (state == DIV) begin
        rem <= rem_nx;
        quo <= quo_nx;
        cnt <= cnt - CW'(1);
      end
      if (load) begin
        res_val   <= ld_val;
        res_aux   <= ld_aux;
        res_rd    <= ld_rd;
        res_zero  <= (ld_val == '0);
        res_carry <= ld_carry;
        res_dz    <= ld_dz;
      end
    end
  end
endmodule

// File: tb/tb_alu_exec_ctrl.sv
// tb/tb_alu_exec_ctrl.sv - directed vector bench for alu_exec_ctrl
module tb_alu_exec_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        op_valid = 1'b0;
  logic        op_ready;
  logic [1:0]  op_opcode = '0;
  logic [15:0] rs1_reg_val = '0;
  logic [15:0] rs2_reg_val = '0;
  logic [2:0]  rd_addr = '0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [15:0] res_val, res_aux;
  logic [2:0]  res_rd;
  logic        res_zero, res_carry, res_dz, busy;

  int checks = 0;
  int errors = 0;

  alu_exec_ctrl #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready),
    .op_opcode(op_opcode), .rs1_reg_val(rs1_reg_val), .rs2_reg_val(rs2_reg_val),
    .rd_addr(rd_addr), .res_valid(res_valid), .res_ready(res_ready),
    .res_val(res_val), .res_aux(res_aux), .res_rd(res_rd), .res_zero(res_zero),
    .res_carry(res_carry), .res_dz(res_dz), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  rd;
    logic [15:0] val;
    logic [15:0] aux;
    logic        zero;
    logic        carry;
    logic        dz;
    int          lat;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_vec(input vec_t v);
    int lat;
    int busy_cnt;
    @(negedge clk);
    chk("op_ready_before", op_ready, 1);
    op_valid    = 1'b1;
    op_opcode   = v.op;
    rs1_reg_val = v.a;
    rs2_reg_val = v.b;
    rd_addr     = v.rd;
    @(posedge clk); #1;
    op_valid = 1'b0;
    lat      = 1;
    busy_cnt = 0;
    while (!res_valid && lat < 40) begin
      if (busy) busy_cnt++;
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, v.lat);
    chk("busy_cycles", busy_cnt, v.lat - 1);
    chk("res_val", res_val, v.val);
    chk("res_aux", res_aux, v.aux);
    chk("res_rd", res_rd, v.rd);
    chk("res_zero", res_zero, v.zero);
    chk("res_carry", res_carry, v.carry);
    chk("res_dz", res_dz, v.dz);
    @(negedge clk);
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    chk("idle_after_handshake", {res_valid, op_ready}, 2'b01);
  endtask

  initial begin
    //          op     a         b         rd    val       aux       z  c  dz lat
    vecs[0] = '{2'd0, 16'h7FFF, 16'h0001, 3'd1, 16'h8000, 16'h0000, 0, 0, 0, 1};
    vecs[1] = '{2'd0, 16'hFFFF, 16'h0001, 3'd2, 16'h0000, 16'h0000, 1, 1, 0, 1};
    vecs[2] = '{2'd1, 16'h0005, 16'h0007, 3'd3, 16'hFFFE, 16'h0000, 0, 1, 0, 1};
    vecs[3] = '{2'd1, 16'h0009, 16'h0009, 3'd6, 16'h0000, 16'h0000, 1, 0, 0, 1};
    vecs[4] = '{2'd2, 16'h1234, 16'h0100, 3'd4, 16'h3400, 16'h0012, 0, 1, 0, 17};
    vecs[5] = '{2'd2, 16'hFFFF, 16'hFFFF, 3'd5, 16'h0001, 16'hFFFE, 0, 1, 0, 17};
    vecs[6] = '{2'd2, 16'h0003, 16'h0005, 3'd7, 16'h000F, 16'h0000, 0, 0, 0, 17};
    vecs[7] = '{2'd3, 16'd100,  16'd7,    3'd2, 16'd14,   16'd2,    0, 0, 0, 17};
    vecs[8] = '{2'd3, 16'h1234, 16'h0000, 3'd1, 16'hFFFF, 16'h1234, 0, 0, 1, 1};
    vecs[9] = '{2'd3, 16'h0005, 16'h0009, 3'd0, 16'h0000, 16'h0005, 1, 0, 0, 17};

    #1;
    chk("reset_outputs", {op_ready, res_valid, busy, res_zero, res_carry, res_dz}, 6'b100000);
    chk("reset_val", {res_val, res_aux}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) do_vec(vecs[i]);

    // Backpressure: result must stay put while writeback stalls.
    @(negedge clk);
    op_valid = 1'b1; op_opcode = 2'd0; rs1_reg_val = 16'h0010; rs2_reg_val = 16'h0020; rd_addr = 3'd5;
    @(posedge clk); #1;
    chk("bp_valid", res_valid, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      op_valid    = ~op_valid;
      op_opcode   = 2'(i);
      rs1_reg_val = 16'($urandom);
      rs2_reg_val = 16'($urandom);
      rd_addr     = 3'(i);
      @(posedge clk); #1;
      chk("bp_hold", {res_valid, op_ready, res_rd, res_val, res_aux}, {1'b1, 1'b0, 3'd5, 16'h0030, 16'h0000});
    end
    @(negedge clk);
    op_valid  = 1'b0;
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    chk("bp_release", {res_valid, op_ready}, 2'b01);
    chk("bp_outputs_kept", res_val, 16'h0030);
    do_vec(vecs[1]);

    // Reset in the middle of a multiply.
    @(negedge clk);
    op_valid = 1'b1; op_opcode = 2'd2; rs1_reg_val = 16'h1234; rs2_reg_val = 16'h0100; rd_addr = 3'd3;
    @(posedge clk); #1;
    op_valid = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    chk("mid_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_reset", {res_valid, busy, op_ready}, 3'b001);
    chk("mid_reset_val", {res_val, res_aux}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    do_vec(vecs[7]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_exec_ctrl.md
# alu_exec_ctrl

Execution controller for the 16-bit CPU's ALU stage. It accepts one decoded operation at a time through a valid/ready handshake and steers the operands to the add, sub, mul or div path selected by the 2-bit `op_opcode`. Add and sub complete in one cycle. Mul runs as an iterative shift-add sequence and div as a restoring divide, each taking WIDTH cycles. The result is presented to writeback through a second valid/ready handshake.

## Interface
- `WIDTH`, default 16: operand/result width. Must be at least 2.
- `clk`  in  1  clock; everything is on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `op_valid`  in  1  an operation is offered.
- `op_ready`  out  1  controller can accept; equals (state==IDLE).
- `op_opcode`  in  2  0=add, 1=sub, 2=mul, 3=div (unsigned).
- `rs1_reg_val`  in  WIDTH  first operand (dividend for div).
- `rs2_reg_val`  in  WIDTH  second operand (divisor for div).
- `rd_addr`  in  3  destination register tag.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  writeback accepts the result.
- `res_val`  out  WIDTH  sum, difference, product low half, or quotient.
- `res_aux`  out  WIDTH  product high half or remainder; 0 for add/sub.
- `res_rd`  out  3  `rd_addr` captured at accept.
- `res_zero`  out  1  `res_val` is 0.
- `res_carry`  out  1  add carry-out; sub borrow (rs1 < rs2 unsigned); mul high half is nonzero; 0 for div.
- `res_dz`  out  1  divide by zero.
- `busy`  out  1  state is MUL or DIV.

## Operation
- States: IDLE, MUL, DIV, DONE.
- **Reset**
  - State goes to IDLE, which makes `op_ready`=1.
  - `res_valid`, `busy` and all result/flag outputs are 0.
  - The iteration counter is 0.
- **Accept:** happens when `op_valid` && `op_ready`. Operands, opcode and `rd_addr` are registered. Inputs are ignored at every other time.
- **IDLE, add/sub:** compute in a WIDTH+1-bit adder, load the result registers, go to DONE.
- **IDLE, mul:** load multiplicand, multiplier, and accumulator=0; set counter=WIDTH; go to MUL.
- **IDLE, div with rs2≠0:** load remainder=0 and quotient=rs1; set counter=WIDTH; go to DIV.
- **IDLE, div with rs2==0:** load `res_val`=all ones, `res_aux`=rs1, `res_dz`=1; go straight to DONE with no iteration.
- **MUL:** one step per cycle.
  - If multiplier LSB is 1, add the multiplicand into the upper half of a 2·WIDTH accumulator (carry kept).
  - Shift {carry, accumulator, multiplier} right by 1.
  - Decrement the counter. On the step where the counter goes 1→0, load the results and go to DONE.
- **DIV:** one step per cycle.
  - Shift {remainder, quotient} left by 1.
  - Trial-subtract the divisor from the remainder. If there is no borrow, keep the difference and set quotient LSB=1.
  - Decrement the counter. At 1→0, load the results and go to DONE.
- **DONE:** `res_valid`=1. When `res_ready`=1, go to IDLE.
  - `res_*` outputs are held stable while `res_valid` && !`res_ready`.
  - `op_ready`=0, so `op_valid` is ignored.
- **Outputs:** registered and updated only on the load into DONE. They keep their values after the result handshake until the next load.
- **Reset mid-operation:** the operation is abandoned, no result is issued, and all outputs return to their reset values.
- **Arithmetic:** all unsigned and modulo 2^WIDTH. The mul product is exact over 2·WIDTH bits.

## Timing
- An accept at edge T0 gives:
  - add/sub and div-by-zero: `res_valid` high after edge T0+1.
  - mul and div: `res_valid` high after edge T0+WIDTH+1 (17 cycles at WIDTH=16).
- Earliest next accept: the cycle after the edge on which `res_valid` && `res_ready`. Peak add/sub throughput is one operation every 2 cycles.
- No combinational path from `op_valid` to `op_ready` or from `res_ready` to `res_valid`.

## Test plan
- **Add:** 0x7FFF+0x0001 → `res_val`=0x8000, carry 0, zero 0, `res_valid` one cycle after accept. 0xFFFF+0x0001 → 0x0000, carry 1, zero 1.
- **Sub:** 0x0005−0x0007 → 0xFFFE, carry 1. 0x0009−0x0009 → 0x0000, zero 1, carry 0. `res_rd` equals the tag given at accept.
- **Mul:**
  - 0x1234×0x0100 → `res_val`=0x3400, `res_aux`=0x0012, carry 1, `res_valid` 17 cycles after accept, `busy` high for 16 cycles.
  - 0xFFFF×0xFFFF → 0x0001 / 0xFFFE.
- **Div:**
  - 100/7 → `res_val`=14, `res_aux`=2, 17-cycle latency.
  - 0x1234/0 → `res_val`=0xFFFF, `res_aux`=0x1234, `res_dz`=1, 1-cycle latency.
- **Backpressure:** hold `res_ready`=0 for 5 cycles while toggling `op_valid` and the operands. Outputs must stay stable and `op_ready` must stay 0. Then raise `res_ready`: the controller is back in IDLE and accepts the next operation.
- **Reset mid-operation:** pull `rst_n` low 8 cycles into a mul. Expect `res_valid`=0, `busy`=0 and `op_ready`=1 immediately. A following 100/7 divide must return 14 r 2.
